seg_display_scanner: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display bank. It holds a hex value and scans it one digit at a time through a single shared `hexTo7Seg` decoder (active-low segments, blank = 7'h7F). Each digit is followed by an all-off dead time to suppress ghosting. Value updates are double-buffered so a frame never shows a mix of old and new digits. It sits between the datapath's debug/result registers and the board's segment and anode pins.

---
 rtl/seg_display_if.sv | 23 ++
 rtl/seg_display_scanner.sv | 185 ++++++++++++++++++
 tb/tb_seg_display_scanner.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_if.sv
// Bundles the scanner's control, value and display-pin signals.
// The master drives enable/load/value/blank_lz; the slave (scanner) drives seg/an/frame_done.
interface seg_display_if #(
  parameter int N_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_done;

  modport master (
    output enable, load, value, blank_lz,
    input  seg, an, frame_done
  );

  modport slave (
    input  enable, load, value, blank_lz,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg_display_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with per-digit dead time,
// tear-free double-buffered value updates and optional leading-zero blanking.
module hexTo7Seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
endmodule

module seg_display_scanner #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_display_if.slave  bus
);
  localparam int VW      = 4 * N_DIGITS;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = (DEAD_CYCLES > 0) ? CNT_W'(DEAD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [VW-1:0]     disp_reg, disp_next;
  logic [VW-1:0]     shadow_reg, shadow_next;
  logic              pending_reg, pending_next;
  logic              frame_done_reg, frame_done_next;
  logic [6:0]        seg_reg, seg_next;
  logic [N_DIGITS-1:0] an_reg, an_next;

  logic              slot_end;
  logic [3:0]        digit_next;
  logic [6:0]        dec_seg;
  logic [N_DIGITS-1:0] lz_mask;
  logic              suppress;

  assign slot_end = (state_reg == DEAD) ? (cnt_reg == DEAD_LAST) : (cnt_reg == DRIVE_LAST);

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    disp_next       = disp_reg;
    shadow_next     = shadow_reg;
    pending_next    = pending_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          disp_next    = bus.value;
          pending_next = 1'b0;
        end
        if (bus.enable) begin
          state_next = DRIVE;
          idx_next   = '0;
          cnt_next   = '0;
          if (pending_reg && !bus.load) begin
            disp_next    = shadow_reg;
            pending_next = 1'b0;
          end
        end
      end
      DRIVE, DEAD: begin
        if (bus.load) begin
          shadow_next  = bus.value;
          pending_next = 1'b1;
        end
        if (!bus.enable) begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end else if (!slot_end) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end else if (state_reg == DRIVE && DEAD_CYCLES > 0) begin
          state_next = DEAD;
          cnt_next   = '0;
        end else begin
          state_next = DRIVE;
          cnt_next   = '0;
          if (idx_reg == LAST_IDX) begin
            // Frame wrap: the only point where a staged value may reach the display.
            idx_next        = '0;
            frame_done_next = 1'b1;
            if (bus.load) begin
              disp_next    = bus.value;
              pending_next = 1'b0;
            end else if (pending_reg) begin
              disp_next    = shadow_reg;
              pending_next = 1'b0;
            end
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they land on the same edge as the state.
  assign digit_next = disp_next[{idx_next, 2'b00} +: 4];

  hexTo7Seg u_dec (
    .hex (digit_next),
    .seg (dec_seg)
  );

  assign lz_mask[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_lz
      assign lz_mask[gi] = (disp_next[VW-1:4*gi] == '0);
    end
  endgenerate

  assign suppress = bus.blank_lz && lz_mask[idx_next];

  always_comb begin
    an_next  = '1;
    seg_next = 7'h7F;
    if (state_next == DRIVE && !suppress) begin
      an_next[idx_next] = 1'b0;
      seg_next          = dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      disp_reg       <= '0;
      shadow_reg     <= '0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      seg_reg        <= 7'h7F;
      an_reg         <= '1;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      disp_reg       <= disp_next;
      shadow_reg     <= shadow_next;
      pending_reg    <= pending_next;
      frame_done_reg <= frame_done_next;
      seg_reg        <= seg_next;
      an_reg         <= an_next;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.an         = an_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: two instances (DEAD_CYCLES=1 and 0) share stimulus and
// are compared every cycle against a frame-position arithmetic model.
module tb_seg_display_scanner;
  localparam int N = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, ld = 1'b0, blz = 1'b0;
  logic [15:0] val = 16'h0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_display_if #(.N_DIGITS(N)) bus1();
  seg_display_if #(.N_DIGITS(N)) bus0();

  assign bus1.enable = en;   assign bus0.enable = en;
  assign bus1.load = ld;     assign bus0.load = ld;
  assign bus1.value = val;   assign bus0.value = val;
  assign bus1.blank_lz = blz; assign bus0.blank_lz = blz;

  seg_display_scanner #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  seg_display_scanner #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state per instance: index 0 is the DEAD_CYCLES=0 DUT, 1 the DEAD_CYCLES=1 DUT.
  bit          m_active [2];
  int          m_t      [2];
  logic [15:0] m_disp   [2];
  logic [15:0] m_shadow [2];
  bit          m_pend   [2];
  bit          m_fd     [2];
  bit          m_blz    [2];

  function automatic int dead_of(int k);
    return (k == 0) ? 0 : 1;
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, k, $time, act, exp);
    end
  endtask

  task automatic model_step(int k);
    int frame;
    frame = N * (R + dead_of(k));
    if (!rst_n) begin
      m_active[k] = 0; m_t[k] = 0; m_disp[k] = '0; m_shadow[k] = '0;
      m_pend[k] = 0; m_fd[k] = 0; m_blz[k] = 0;
      return;
    end
    m_fd[k]  = 0;
    m_blz[k] = blz;
    if (!m_active[k]) begin
      if (ld) begin m_disp[k] = val; m_pend[k] = 0; end
      if (en) begin
        m_active[k] = 1; m_t[k] = 0;
        if (m_pend[k]) begin m_disp[k] = m_shadow[k]; m_pend[k] = 0; end
      end
    end else if (!en) begin
      m_active[k] = 0;
      if (ld) begin m_shadow[k] = val; m_pend[k] = 1; end
    end else begin
      m_t[k]++;
      if (m_t[k] == frame) begin
        m_t[k] = 0; m_fd[k] = 1;
        if (ld) begin m_disp[k] = val; m_pend[k] = 0; end
        else if (m_pend[k]) begin m_disp[k] = m_shadow[k]; m_pend[k] = 0; end
      end else if (ld) begin
        m_shadow[k] = val; m_pend[k] = 1;
      end
    end
  endtask

  task automatic expect_out(int k, output logic [N-1:0] an_e, output logic [6:0] seg_e,
                            output logic fd_e);
    int p, d, w;
    logic [15:0] hi;
    an_e  = '1;
    seg_e = 7'h7F;
    fd_e  = m_fd[k];
    if (m_active[k]) begin
      p = R + dead_of(k);
      d = m_t[k] / p;
      w = m_t[k] % p;
      if (w < R) begin
        hi = m_disp[k] >> (4 * d);
        if (!(m_blz[k] && d > 0 && hi == 16'h0)) begin
          an_e[d] = 1'b0;
          seg_e   = seg_tab[hi[3:0]];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step(0);
    model_step(1);
  end

  initial forever begin
    logic [N-1:0] an_e, an_a;
    logic [6:0]   seg_e, seg_a;
    logic         fd_e, fd_a;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      expect_out(k, an_e, seg_e, fd_e);
      an_a  = (k == 0) ? bus0.an : bus1.an;
      seg_a = (k == 0) ? bus0.seg : bus1.seg;
      fd_a  = (k == 0) ? bus0.frame_done : bus1.frame_done;
      chk("model_an", k, 32'(an_a), 32'(an_e));
      chk("model_seg", k, 32'(seg_a), 32'(seg_e));
      chk("model_frame_done", k, 32'(fd_a), 32'(fd_e));
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.frame_done && n < 200);
    checks++;
    if (!bus1.frame_done) begin
      errors++;
      $display("FAIL wait_frame_done dut1 actual=timeout required=pulse within 200 cycles");
    end
  endtask

  task automatic lit(string name, logic [N-1:0] an_e, logic [6:0] seg_e);
    chk({name, "_an"}, 1, 32'(bus1.an), 32'(an_e));
    chk({name, "_seg"}, 1, 32'(bus1.seg), 32'(seg_e));
  endtask

  initial begin
    int fd1_first, fd0_first, fd0_second;
    logic [15:0] masks [4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};

    step(3);
    rst_n = 1'b1;
    step(2);
    lit("reset_idle", 4'hF, 7'h7F);

    // Basic scan: load in IDLE, then enable.
    val = 16'h12A0; ld = 1'b1;
    step(1);
    ld = 1'b0; en = 1'b1;
    fd1_first = -1; fd0_first = -1; fd0_second = -1;
    for (int c = 0; c < 34; c++) begin
      step(1);
      case (c)
        0:  lit("scan_d0", 4'hE, 7'h40);
        4:  begin
              lit("scan_dead", 4'hF, 7'h7F);
              chk("nodead_d1_an", 0, 32'(bus0.an), 32'hD);
            end
        5:  lit("scan_d1", 4'hD, 7'h08);
        10: lit("scan_d2", 4'hB, 7'h24);
        15: lit("scan_d3", 4'h7, 7'h79);
        default: ;
      endcase
      if (bus1.frame_done && fd1_first < 0) fd1_first = c;
      if (bus0.frame_done) begin
        if (fd0_first < 0) fd0_first = c;
        else if (fd0_second < 0) fd0_second = c;
      end
    end
    chk("frame_done_first", 1, 32'(fd1_first), 32'd20);
    chk("frame_done_first", 0, 32'(fd0_first), 32'd16);
    chk("frame_done_second", 0, 32'(fd0_second), 32'd32);

    // Leading-zero suppression.
    blz = 1'b1; val = 16'h0050; ld = 1'b1;
    step(1);
    ld = 1'b0;
    wait_fd();
    lit("lz50_d0", 4'hE, 7'h40);
    step(5);  lit("lz50_d1", 4'hD, 7'h12);
    step(5);  lit("lz50_d2", 4'hF, 7'h7F);
    step(5);  lit("lz50_d3", 4'hF, 7'h7F);
    val = 16'h0000; ld = 1'b1;
    step(1);
    ld = 1'b0;
    wait_fd();
    lit("lz0_d0", 4'hE, 7'h40);
    step(5);  lit("lz0_d1", 4'hF, 7'h7F);

    // Tear-free update.
    blz = 1'b0; val = 16'h1111; ld = 1'b1;
    step(1);
    ld = 1'b0;
    wait_fd();
    step(6);
    val = 16'h2222; ld = 1'b1;
    step(1);
    ld = 1'b0;
    step(3);  lit("tear_d2", 4'hB, 7'h79);
    step(5);  lit("tear_d3", 4'h7, 7'h79);
    wait_fd();
    lit("tear_new_d0", 4'hE, 7'h24);
    step(2);
    val = 16'h3333; ld = 1'b1;
    step(1);
    ld = 1'b0;
    step(5);
    val = 16'h4444; ld = 1'b1;
    step(1);
    ld = 1'b0;
    wait_fd();
    lit("last_load_d0", 4'hE, 7'h19);
    step(15); lit("last_load_d3", 4'h7, 7'h19);

    // Load on the wrap edge goes straight to the display.
    wait_fd();
    step(19);
    val = 16'hBEEF; ld = 1'b1;
    step(1);
    ld = 1'b0;
    chk("wrap_frame_done", 1, 32'(bus1.frame_done), 32'd1);
    lit("wrap_d0", 4'hE, 7'h0E);
    step(5);  lit("wrap_d1", 4'hD, 7'h06);
    step(10); lit("wrap_d3", 4'h7, 7'h03);
    wait_fd();
    lit("wrap_next_d0", 4'hE, 7'h0E);

    // Enable drop mid digit 2, then re-enable.
    step(11);
    en = 1'b0;
    step(1);
    lit("drop", 4'hF, 7'h7F);
    chk("drop_an", 0, 32'(bus0.an), 32'hF);
    en = 1'b1;
    step(1);
    lit("reenable_d0", 4'hE, 7'h0E);
    chk("reenable_an", 0, 32'(bus0.an), 32'hE);

    // Asynchronous reset mid-DRIVE: outputs blank with no clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_reset", 4'hF, 7'h7F);
    chk("async_reset_an", 0, 32'(bus0.an), 32'hF);
    en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    lit("post_reset_idle", 4'hF, 7'h7F);
    en = 1'b1;

    // Randomized phase, checked every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if (en) begin
        if ($urandom_range(0, 63) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      ld  = ($urandom_range(0, 7) == 0);
      val = 16'($urandom()) & masks[$urandom_range(0, 3)];
      if ($urandom_range(0, 99) == 0) blz = ~blz;
      if (i == 2000) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        lit("rand_async_reset", 4'hF, 7'h7F);
        step(2);
        rst_n = 1'b1;
      end
    end
    ld = 1'b0;
    step(2);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
